// File: rtl/cpu_sequencer_pkg.sv
// Shared definitions for the CPU sequencer: FSM state encoding and the
// instruction field positions used to split the instruction register.
package cpu_sequencer_pkg;

    // Five sequencer states need three bits of encoding.
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_WRITEBACK = 3'd4
    } seq_state_t;

    // Instruction field bit positions (decoder-facing fields).
    localparam int GROUP_MSB = 15;
    localparam int GROUP_LSB = 13;
    localparam int CMD_MSB   = 12;
    localparam int CMD_LSB   = 10;

endpackage

// File: rtl/cpu_sequencer_program_counter.sv
// Program counter for the sequencer. A load takes priority over an increment;
// the increment wraps modulo 2^ADDR_WIDTH.
module cpu_sequencer_program_counter #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  load,
    input  logic [ADDR_WIDTH-1:0] load_val,
    input  logic                  inc,
    output logic [ADDR_WIDTH-1:0] pc
);

    // PC register: branch target load, sequential increment or hold.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)  pc <= '0;
        else if (load) pc <= load_val;
        else if (inc)  pc <= pc + 1'b1;
    end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle CPU sequencer: fetch -> decode -> execute -> writeback.
// Owns the instruction register, branch/write flops and the retired counter;
// the PC lives in cpu_sequencer_program_counter.
// Optional build macro SEQ_SINGLE_STEP_EN adds a 'step' input: one instruction
// per step pulse (with run=1), always returning to IDLE after writeback.
module cpu_sequencer
    import cpu_sequencer_pkg::*;
#(
    parameter int ADDR_WIDTH   = 8,
    parameter int INSTR_WIDTH  = 16,
    parameter int RETIRE_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    run,
`ifdef SEQ_SINGLE_STEP_EN
    input  logic                    step,
`endif
    output logic [ADDR_WIDTH-1:0]   instr_addr,
    output logic                    instr_rd_en,
    input  logic [INSTR_WIDTH-1:0]  instr_rdata,
    input  logic                    instr_valid,
    output logic [2:0]              command_group,
    output logic [2:0]              command,
    input  logic                    write_enable,
    input  logic                    branch_select,
    input  logic                    alu_cond,
    output logic                    reg_we,
    output logic                    busy,
    output logic [RETIRE_WIDTH-1:0] retired
);

    seq_state_t             state_q, state_d;
    logic [INSTR_WIDTH-1:0] ir_q;
    logic                   take_q, we_q;
    logic                   pc_load, pc_inc;
    logic [ADDR_WIDTH-1:0]  pc;
    logic                   start_req, continue_run;
    logic                   unused_ir_bits;

`ifdef SEQ_SINGLE_STEP_EN
    // Single-step: leave IDLE only on a step pulse, never chain instructions.
    assign start_req    = run & step;
    assign continue_run = 1'b0;
`else
    assign start_req    = run;
    assign continue_run = run;
`endif

    // Only the decoder fields and the target field are consumed from ir.
    assign unused_ir_bits = ^ir_q;

    assign command_group = ir_q[GROUP_MSB:GROUP_LSB];
    assign command       = ir_q[CMD_MSB:CMD_LSB];
    assign instr_addr    = pc;
    assign busy          = (state_q != S_IDLE);

    cpu_sequencer_program_counter #(.ADDR_WIDTH(ADDR_WIDTH)) u_pc (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (pc_load),
        .load_val (ir_q[ADDR_WIDTH-1:0]),
        .inc      (pc_inc),
        .pc       (pc)
    );

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // Next-state and per-state strobes; writeback outputs exist for one cycle only.
    always_comb begin
        state_d     = state_q;
        instr_rd_en = 1'b0;
        reg_we      = 1'b0;
        pc_load     = 1'b0;
        pc_inc      = 1'b0;
        unique case (state_q)
            S_IDLE:    if (start_req) state_d = S_FETCH;
            S_FETCH: begin
                instr_rd_en = 1'b1;
                if (instr_valid) state_d = S_DECODE;
            end
            S_DECODE:  state_d = S_EXECUTE;
            S_EXECUTE: state_d = S_WRITEBACK;
            S_WRITEBACK: begin
                reg_we  = we_q;
                pc_load = take_q;
                pc_inc  = ~take_q;
                state_d = continue_run ? S_FETCH : S_IDLE;
            end
            default:   state_d = S_IDLE;
        endcase
    end

    // Instruction register captures only on a valid beat while fetching.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                             ir_q <= '0;
        else if (state_q == S_FETCH && instr_valid) ir_q <= instr_rdata;
    end

    // Branch resolution and write intent are latched in EXECUTE for writeback.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            take_q <= 1'b0;
            we_q   <= 1'b0;
        end else if (state_q == S_EXECUTE) begin
            take_q <= branch_select & alu_cond;
            we_q   <= write_enable;
        end
    end

    // Retired-instruction counter, wraps silently.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                     retired <= '0;
        else if (state_q == S_WRITEBACK)  retired <= retired + 1'b1;
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: acts as program memory (random wait states) and
// decoder, and checks each instruction against an instruction-level model.
module tb_cpu_sequencer;

    localparam logic [2:0] G_NOP = 3'd0;
    localparam logic [2:0] G_MOV = 3'd1;
    localparam logic [2:0] G_JMP = 3'd4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        run = 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
    logic        step = 1'b0;
`endif
    logic [7:0]  instr_addr;
    logic        instr_rd_en;
    logic [15:0] instr_rdata = '0;
    logic        instr_valid = 1'b0;
    logic [2:0]  command_group, command;
    logic        write_enable, branch_select;
    logic        alu_cond = 1'b0;
    logic        reg_we, busy;
    logic [7:0]  retired;

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] m_pc;
    logic [7:0] m_ret;

    always #5 clk = ~clk;

    // Decoder model: MOV writes, JMP branches, every other group is a no-op.
    assign write_enable  = (command_group == G_MOV);
    assign branch_select = (command_group == G_JMP);

    cpu_sequencer #(.ADDR_WIDTH(8), .INSTR_WIDTH(16), .RETIRE_WIDTH(8)) dut (
        .clk(clk), .reset_n(reset_n), .run(run),
`ifdef SEQ_SINGLE_STEP_EN
        .step(step),
`endif
        .instr_addr(instr_addr), .instr_rd_en(instr_rd_en),
        .instr_rdata(instr_rdata), .instr_valid(instr_valid),
        .command_group(command_group), .command(command),
        .write_enable(write_enable), .branch_select(branch_select),
        .alu_cond(alu_cond), .reg_we(reg_we), .busy(busy), .retired(retired)
    );

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Bring the DUT into FETCH (from IDLE if needed), bounded.
    task automatic enter_fetch();
        int n = 0;
        run = 1'b1;
`ifdef SEQ_SINGLE_STEP_EN
        if (!busy) begin step = 1'b1; tick(); step = 1'b0; end
`endif
        while (!instr_rd_en && n < 20) begin tick(); n++; end
        if (!instr_rd_en) begin
            n_cmp++; n_err++;
            $display("FAIL enter_fetch: instr_rd_en never rose within %0d cycles", n);
        end
    endtask

    // Drive one instruction through the DUT, returning what was observed.
    task automatic run_instr(input logic [15:0] instr, input int waits, input bit alu,
                             input bit drop_run, output logic [7:0] addr,
                             output int rd_cycles, output bit addr_ok,
                             output int we_pulses, output int lat);
        int n;
        enter_fetch();
        alu_cond = alu;
        addr = instr_addr; rd_cycles = 0; addr_ok = 1'b1; we_pulses = 0; lat = 0;
        while (instr_rd_en && rd_cycles < 64) begin
            if (instr_addr !== addr) addr_ok = 1'b0;
            if (reg_we) we_pulses++;
            if (rd_cycles == waits) begin instr_valid = 1'b1; instr_rdata = instr; end
            else begin instr_valid = 1'b0; instr_rdata = 16'($urandom); end
            rd_cycles++;
            tick(); lat++;
        end
        n = 0;
        while (busy && !instr_rd_en && n < 16) begin
            if (reg_we) we_pulses++;
            if (drop_run && n == 1) run = 1'b0;
            instr_valid = 1'($urandom);   // must be ignored outside FETCH
            instr_rdata = 16'($urandom);
            tick(); lat++; n++;
        end
        instr_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; run = 1'b0;
        tick(); tick();
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (instr_rd_en !== 1'b0) begin n_err++; $display("FAIL reset_rd_en: got %b want 0", instr_rd_en); end
        n_cmp++; if (reg_we !== 1'b0) begin n_err++; $display("FAIL reset_reg_we: got %b want 0", reg_we); end
        n_cmp++; if (instr_addr !== 8'h00) begin n_err++; $display("FAIL reset_pc: got %h want 00", instr_addr); end
        n_cmp++; if (retired !== 8'h00) begin n_err++; $display("FAIL reset_retired: got %h want 00", retired); end
        n_cmp++; if ({command_group, command} !== 6'h00) begin n_err++; $display("FAIL reset_ir: got %h want 00", {command_group, command}); end
        reset_n = 1'b1;
        tick(); tick(); tick();
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL idle_hold: busy got %b want 0 with run=0", busy); end
        m_pc = 8'h00; m_ret = 8'h00;
    endtask

    task automatic test_mov();
        logic [15:0] instr; logic [7:0] a; int rc, wp, lat; bit aok;
        instr = {G_MOV, 3'd2, 10'h0AB};
        run_instr(instr, 0, 1'b0, 1'b0, a, rc, aok, wp, lat);
        m_pc = m_pc + 8'd1; m_ret = m_ret + 8'd1;
        n_cmp++; if (a !== 8'h00) begin n_err++; $display("FAIL mov_addr: got %h want 00", a); end
        n_cmp++; if (lat != 4) begin n_err++; $display("FAIL mov_latency: got %0d want 4", lat); end
        n_cmp++; if (wp != 1) begin n_err++; $display("FAIL mov_reg_we: got %0d pulses want 1", wp); end
        n_cmp++; if (instr_addr !== m_pc) begin n_err++; $display("FAIL mov_pc: got %h want %h", instr_addr, m_pc); end
        n_cmp++; if (retired !== m_ret) begin n_err++; $display("FAIL mov_retired: got %h want %h", retired, m_ret); end
        n_cmp++; if (command_group !== G_MOV || command !== 3'd2) begin n_err++; $display("FAIL mov_fields: got %h/%h want %h/2", command_group, command, G_MOV); end
    endtask

    task automatic test_wait_states();
        logic [15:0] instr; logic [7:0] a; int rc, wp, lat; bit aok;
        instr = {G_NOP, 3'd5, 10'h155};
        run_instr(instr, 3, 1'b0, 1'b0, a, rc, aok, wp, lat);
        n_cmp++; if (a !== m_pc) begin n_err++; $display("FAIL wait_addr: got %h want %h", a, m_pc); end
        m_pc = m_pc + 8'd1; m_ret = m_ret + 8'd1;
        n_cmp++; if (rc != 4) begin n_err++; $display("FAIL wait_rd_en_cycles: got %0d want 4", rc); end
        n_cmp++; if (!aok) begin n_err++; $display("FAIL wait_addr_stable: got unstable want stable"); end
        n_cmp++; if (lat != 7) begin n_err++; $display("FAIL wait_latency: got %0d want 7", lat); end
        n_cmp++; if (command_group !== G_NOP || command !== 3'd5) begin n_err++; $display("FAIL wait_ir: got %h/%h want 0/5", command_group, command); end
        n_cmp++; if (wp != 0) begin n_err++; $display("FAIL wait_reg_we: got %0d want 0", wp); end
    endtask

    task automatic test_jmp();
        logic [15:0] instr; logic [7:0] a; int rc, wp, lat; bit aok;
        instr = {G_JMP, 3'd0, 2'b00, 8'h20};
        run_instr(instr, 1, 1'b1, 1'b0, a, rc, aok, wp, lat);
        m_pc = 8'h20; m_ret = m_ret + 8'd1;
        n_cmp++; if (instr_addr !== m_pc) begin n_err++; $display("FAIL jmp_taken_pc: got %h want %h", instr_addr, m_pc); end
        n_cmp++; if (wp != 0) begin n_err++; $display("FAIL jmp_reg_we: got %0d want 0", wp); end
        run_instr(instr, 0, 1'b0, 1'b0, a, rc, aok, wp, lat);
        m_pc = m_pc + 8'd1; m_ret = m_ret + 8'd1;
        n_cmp++; if (instr_addr !== 8'h21) begin n_err++; $display("FAIL jmp_not_taken_pc: got %h want 21", instr_addr); end
    endtask

    task automatic test_pc_wrap();
        logic [15:0] instr; logic [7:0] a; int rc, wp, lat; bit aok;
        instr = {G_JMP, 3'd1, 2'b11, 8'hFF};
        run_instr(instr, 0, 1'b1, 1'b0, a, rc, aok, wp, lat);
        m_pc = 8'hFF; m_ret = m_ret + 8'd1;
        n_cmp++; if (instr_addr !== 8'hFF) begin n_err++; $display("FAIL wrap_setup_pc: got %h want ff", instr_addr); end
        instr = {G_NOP, 13'h0};
        run_instr(instr, 0, 1'b0, 1'b0, a, rc, aok, wp, lat);
        m_pc = 8'h00; m_ret = m_ret + 8'd1;
        n_cmp++; if (instr_addr !== 8'h00) begin n_err++; $display("FAIL pc_wrap: got %h want 00", instr_addr); end
    endtask

    task automatic test_random();
        logic [15:0] instr; logic [7:0] a, exp_pc; logic [2:0] grp;
        int rc, wp, lat, waits; bit aok, alu, bad;
        for (int i = 0; i < 40; i++) begin
            grp = 3'($urandom_range(0, 7));
            instr = {grp, 13'($urandom)};
            waits = $urandom_range(0, 3);
            alu = 1'($urandom);
            run_instr(instr, waits, alu, 1'b0, a, rc, aok, wp, lat);
            exp_pc = (grp == G_JMP && alu) ? instr[7:0] : m_pc + 8'd1;
            bad = (a !== m_pc) || !aok || (rc != waits + 1) || (lat != waits + 4) ||
                  (wp != ((grp == G_MOV) ? 1 : 0)) || (instr_addr !== exp_pc) ||
                  (retired !== m_ret + 8'd1) || (command_group !== grp) || (command !== instr[12:10]);
            n_cmp++;
            if (bad) begin
                n_err++;
                $display("FAIL rand[%0d] instr=%h: got addr=%h rd=%0d lat=%0d we=%0d pc=%h ret=%h want addr=%h rd=%0d lat=%0d we=%0d pc=%h ret=%h",
                         i, instr, a, rc, lat, wp, instr_addr, retired, m_pc, waits + 1, waits + 4,
                         (grp == G_MOV) ? 1 : 0, exp_pc, m_ret + 8'd1);
            end
            m_pc = exp_pc; m_ret = m_ret + 8'd1;
        end
    endtask

    task automatic test_run_drop();
        logic [15:0] instr; logic [7:0] a; int rc, wp, lat, n; bit aok;
        instr = {G_MOV, 3'd3, 10'h3C0};
        run_instr(instr, 0, 1'b0, 1'b1, a, rc, aok, wp, lat);
        m_pc = m_pc + 8'd1; m_ret = m_ret + 8'd1;
        n_cmp++; if (wp != 1) begin n_err++; $display("FAIL drop_wb_completes: got %0d pulses want 1", wp); end
        repeat (5) tick();
        n_cmp++; if (busy !== 1'b0 || instr_rd_en !== 1'b0) begin n_err++; $display("FAIL drop_idle: busy/rd_en got %b/%b want 0/0", busy, instr_rd_en); end
        n_cmp++; if (instr_addr !== m_pc) begin n_err++; $display("FAIL drop_pc_held: got %h want %h", instr_addr, m_pc); end
        n_cmp++; if (retired !== m_ret) begin n_err++; $display("FAIL drop_retired: got %h want %h", retired, m_ret); end
        n = 0;
        enter_fetch();
        n_cmp++; if (instr_addr !== m_pc) begin n_err++; $display("FAIL resume_pc: got %h want %h", instr_addr, m_pc); end
    endtask

    task automatic test_retired_wrap();
        logic [15:0] instr; logic [7:0] a; int rc, wp, lat, guard; bit aok;
        instr = {G_NOP, 13'h0};
        guard = 0;
        while (m_ret != 8'hFF && guard < 300) begin
            run_instr(instr, 0, 1'b0, 1'b0, a, rc, aok, wp, lat);
            m_pc = m_pc + 8'd1; m_ret = m_ret + 8'd1; guard++;
        end
        n_cmp++; if (retired !== 8'hFF) begin n_err++; $display("FAIL retired_pre_wrap: got %h want ff", retired); end
        run_instr(instr, 0, 1'b0, 1'b0, a, rc, aok, wp, lat);
        m_pc = m_pc + 8'd1; m_ret = m_ret + 8'd1;
        n_cmp++; if (retired !== 8'h00) begin n_err++; $display("FAIL retired_wrap: got %h want 00", retired); end
    endtask

    task automatic test_reset_in_wb();
        bit saw_we;
        enter_fetch();
        alu_cond = 1'b0;
        instr_valid = 1'b1; instr_rdata = {G_MOV, 3'd1, 10'h011};
        tick(); instr_valid = 1'b0;   // DECODE
        tick();                        // EXECUTE
        tick();                        // WRITEBACK
        n_cmp++; if (reg_we !== 1'b1) begin n_err++; $display("FAIL rstwb_pre_we: got %b want 1", reg_we); end
        reset_n = 1'b0;
        #1;
        n_cmp++; if (reg_we !== 1'b0) begin n_err++; $display("FAIL rstwb_reg_we: got %b want 0", reg_we); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rstwb_busy: got %b want 0", busy); end
        n_cmp++; if (instr_addr !== 8'h00) begin n_err++; $display("FAIL rstwb_pc: got %h want 00", instr_addr); end
        n_cmp++; if (retired !== 8'h00) begin n_err++; $display("FAIL rstwb_retired: got %h want 00", retired); end
        saw_we = 1'b0;
        repeat (3) begin tick(); if (reg_we) saw_we = 1'b1; end
        reset_n = 1'b1;
        repeat (6) begin tick(); if (reg_we) saw_we = 1'b1; end
        n_cmp++; if (saw_we) begin n_err++; $display("FAIL rstwb_no_late_we: got pulse want none"); end
        m_pc = 8'h00; m_ret = 8'h00;
    endtask

`ifdef SEQ_SINGLE_STEP_EN
    task automatic test_step();
        logic [15:0] instr; logic [7:0] a; int rc, wp, lat; bit aok;
        run = 1'b1; step = 1'b0;
        repeat (4) tick();
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL step_wait: busy got %b want 0 without step", busy); end
        instr = {G_MOV, 3'd0, 10'h000};
        for (int k = 0; k < 2; k++) begin
            run_instr(instr, 0, 1'b0, 1'b0, a, rc, aok, wp, lat);
            m_pc = m_pc + 8'd1; m_ret = m_ret + 8'd1;
            tick();
            n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL step_idle[%0d]: busy got %b want 0", k, busy); end
        end
        n_cmp++; if (retired !== 8'd2) begin n_err++; $display("FAIL step_retired: got %0d want 2", retired); end
        n_cmp++; if (instr_addr !== m_pc) begin n_err++; $display("FAIL step_pc: got %h want %h", instr_addr, m_pc); end
    endtask
`endif

    initial begin
        test_reset();
        test_mov();
        test_wait_states();
        test_jmp();
        test_pc_wrap();
        test_random();
        test_run_drop();
        test_retired_wrap();
        test_reset_in_wb();
`ifdef SEQ_SINGLE_STEP_EN
        test_step();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "watchdog expired");
    end

endmodule
